// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for a 5-stage RV32 pipeline: load-use, multi-cycle MDU and taken-branch control.
// Defining HAZARD_PERF_EN builds the stall_cycles / flush_events counters; otherwise those ports read 0.
module hazard_ctrl_unit #(
   parameter int LOAD_LAT = 1,
   parameter int MDU_LAT  = 4,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr_E,
   input  logic [31:0]      instr_M,
   input  logic [31:0]      instr_W,
   input  logic             reg_wr_en_M,
   input  logic             reg_wr_en_W,
   input  logic             is_taken,
   output logic [1:0]       forward_opA,
   output logic [1:0]       forward_opB,
   output logic             pc_enable,
   output logic             IF_ID_enable,
   output logic             ID_EX_enable,
   output logic             EX_ME_enable,
   output logic             ME_WB_enable,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             EX_ME_flush,
   output logic             ME_WB_flush,
   output logic             mdu_start,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [3:0] LD_INIT   = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
   localparam logic [3:0] MDU_INIT  = (MDU_LAT > 1) ? 4'(MDU_LAT - 2) : 4'd0;

   typedef enum logic [1:0] {RUN, LD_HOLD, LD_REL, MDU_BUSY} state_t;

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [6:0] op_E, op_M;
   logic [4:0] rs1_E, rs2_E, rd_M, rd_W;
   logic       uses_rs1, uses_rs2, load_use, mdu_op, branch;
   logic       do_hold, do_rel, do_br;
   logic       unused_bits;

   assign op_E  = instr_E[6:0];
   assign op_M  = instr_M[6:0];
   assign rs1_E = instr_E[19:15];
   assign rs2_E = instr_E[24:20];
   assign rd_M  = instr_M[11:7];
   assign rd_W  = instr_W[11:7];
   assign unused_bits = ^{instr_E[14:7], instr_M[31:12], instr_W[31:12], instr_W[6:0]};

   // U/J-type immediates overlap the rs fields, so only real register reads may stall
   assign uses_rs1 = !((op_E == OP_LUI) || (op_E == OP_AUIPC) || (op_E == OP_JAL));
   assign uses_rs2 = (op_E == OP_OP) || (op_E == OP_STORE) || (op_E == OP_BRANCH);

   assign load_use = (op_M == OP_LOAD) && reg_wr_en_M && (rd_M != 5'd0) &&
                     ((uses_rs1 && (rd_M == rs1_E)) || (uses_rs2 && (rd_M == rs2_E)));
   assign mdu_op   = (op_E == OP_OP) && (instr_E[31:25] == 7'b0000001) && (MDU_LAT > 1);
   assign branch   = is_taken && ((op_E == OP_BRANCH) || (op_E == OP_JAL) || (op_E == OP_JALR));

   always_comb begin
      forward_opA = 2'b00;
      forward_opB = 2'b00;
      if (!rst) begin
         if (reg_wr_en_M && (rd_M != 5'd0) && (rd_M == rs1_E))      forward_opA = 2'b01;
         else if (reg_wr_en_W && (rd_W != 5'd0) && (rd_W == rs1_E)) forward_opA = 2'b10;
         if (reg_wr_en_M && (rd_M != 5'd0) && (rd_M == rs2_E))      forward_opB = 2'b01;
         else if (reg_wr_en_W && (rd_W != 5'd0) && (rd_W == rs2_E)) forward_opB = 2'b10;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // do_rel covers both the load release and the MDU hold: identical output pattern
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      do_hold   = 1'b0;
      do_rel    = 1'b0;
      do_br     = 1'b0;
      mdu_start = 1'b0;
      case (state)
         RUN: begin
            if (load_use) begin
               if (LOAD_LAT == 1) begin
                  do_rel = 1'b1;
               end else begin
                  do_hold = 1'b1;
                  cnt_n   = LD_INIT;
                  state_n = (LD_INIT != 4'd0) ? LD_HOLD : LD_REL;
               end
            end else if (mdu_op) begin
               do_rel    = 1'b1;
               mdu_start = 1'b1;
               cnt_n     = MDU_INIT;
               state_n   = MDU_BUSY;
            end else if (branch) begin
               do_br = 1'b1;
            end
         end
         LD_HOLD: begin
            do_hold = 1'b1;
            cnt_n   = cnt - 4'd1;
            if (cnt <= 4'd1) state_n = LD_REL;
         end
         LD_REL: begin
            do_rel  = 1'b1;
            cnt_n   = 4'd0;
            state_n = RUN;
         end
         MDU_BUSY: begin
            if (cnt == 4'd0) begin
               state_n = RUN;
            end else begin
               do_rel = 1'b1;
               cnt_n  = cnt - 4'd1;
            end
         end
         default: begin
            state_n = RUN;
            cnt_n   = 4'd0;
         end
      endcase
      if (rst) begin
         do_hold   = 1'b0;
         do_rel    = 1'b0;
         do_br     = 1'b0;
         mdu_start = 1'b0;
      end
   end

   assign pc_enable    = !(do_hold || do_rel);
   assign IF_ID_enable = !(do_hold || do_rel);
   assign ID_EX_enable = !(do_hold || do_rel || do_br);
   assign EX_ME_enable = !do_hold;
   assign ME_WB_enable = 1'b1;
   assign IF_ID_flush  = do_br;
   assign ID_EX_flush  = do_br;
   assign EX_ME_flush  = do_rel;
   assign ME_WB_flush  = do_hold;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_enable) stall_q <= stall_q + CNT_W'(1);
         if (do_br)      flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios plus randomized traffic against a schedule-based reference.
// dut_a runs LOAD_LAT=3 / MDU_LAT=4, dut_b runs LOAD_LAT=1 / MDU_LAT=1 on the same inputs.
module tb_hazard_ctrl_unit;
   localparam logic [6:0] O_OP = 7'h33, O_LOAD = 7'h03, O_STORE = 7'h23, O_BR = 7'h63;
   localparam logic [6:0] O_LUI = 7'h37, O_AUIPC = 7'h17, O_JAL = 7'h6f, O_JALR = 7'h67, O_IMM = 7'h13;
   // {pc, if_id, id_ex, ex_me, me_wb enables, if_id, id_ex, ex_me, me_wb flushes, mdu_start}
   localparam logic [9:0] C_NORM = 10'b1111100000;
   localparam logic [9:0] C_HOLD = 10'b0000100010;
   localparam logic [9:0] C_REL  = 10'b0001100100;
   localparam logic [9:0] C_MDUS = 10'b0001100101;
   localparam logic [9:0] C_BR   = 10'b1101111000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr_E = '0, instr_M = '0, instr_W = '0;
   logic        reg_wr_en_M = 1'b0, reg_wr_en_W = 1'b0, is_taken = 1'b0;
   wire  [9:0]  ctl_a, ctl_b;
   wire  [1:0]  fa_a, fb_a, fa_b, fb_b;
   wire  [31:0] st_a, fl_a, st_b, fl_b;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [9:0]  sched_a[$];

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.LOAD_LAT(3), .MDU_LAT(4), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .instr_E(instr_E), .instr_M(instr_M), .instr_W(instr_W),
      .reg_wr_en_M(reg_wr_en_M), .reg_wr_en_W(reg_wr_en_W), .is_taken(is_taken),
      .forward_opA(fa_a), .forward_opB(fb_a),
      .pc_enable(ctl_a[9]), .IF_ID_enable(ctl_a[8]), .ID_EX_enable(ctl_a[7]), .EX_ME_enable(ctl_a[6]),
      .ME_WB_enable(ctl_a[5]), .IF_ID_flush(ctl_a[4]), .ID_EX_flush(ctl_a[3]), .EX_ME_flush(ctl_a[2]),
      .ME_WB_flush(ctl_a[1]), .mdu_start(ctl_a[0]), .stall_cycles(st_a), .flush_events(fl_a));

   hazard_ctrl_unit #(.LOAD_LAT(1), .MDU_LAT(1), .CNT_W(32)) dut_b (
      .clk(clk), .rst(rst), .instr_E(instr_E), .instr_M(instr_M), .instr_W(instr_W),
      .reg_wr_en_M(reg_wr_en_M), .reg_wr_en_W(reg_wr_en_W), .is_taken(is_taken),
      .forward_opA(fa_b), .forward_opB(fb_b),
      .pc_enable(ctl_b[9]), .IF_ID_enable(ctl_b[8]), .ID_EX_enable(ctl_b[7]), .EX_ME_enable(ctl_b[6]),
      .ME_WB_enable(ctl_b[5]), .IF_ID_flush(ctl_b[4]), .ID_EX_flush(ctl_b[3]), .EX_ME_flush(ctl_b[2]),
      .ME_WB_flush(ctl_b[1]), .mdu_start(ctl_b[0]), .stall_cycles(st_b), .flush_events(fl_b));

   function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7);
      return {f7, rs2, rs1, 3'b000, rd, op};
   endfunction

   function automatic bit reads_rs1(logic [6:0] op);
      return !(op == O_LUI || op == O_AUIPC || op == O_JAL);
   endfunction

   function automatic bit reads_rs2(logic [6:0] op);
      return (op == O_OP || op == O_STORE || op == O_BR);
   endfunction

   function automatic bit ref_load_use(logic [31:0] e, logic [31:0] m, logic wm);
      if (m[6:0] != O_LOAD || !wm || m[11:7] == 5'd0) return 1'b0;
      return (reads_rs1(e[6:0]) && m[11:7] == e[19:15]) || (reads_rs2(e[6:0]) && m[11:7] == e[24:20]);
   endfunction

   function automatic bit ref_mul(logic [31:0] e);
      return e[6:0] == O_OP && e[31:25] == 7'h01;
   endfunction

   function automatic bit ref_branch(logic [31:0] e, logic tk);
      return tk && (e[6:0] == O_BR || e[6:0] == O_JAL || e[6:0] == O_JALR);
   endfunction

   function automatic logic [1:0] ref_fwd(logic [4:0] rs, logic [31:0] m, logic wm, logic [31:0] w, logic ww);
      if (wm && m[11:7] != 5'd0 && m[11:7] == rs) return 2'b01;
      if (ww && w[11:7] != 5'd0 && w[11:7] == rs) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [6:0] op;
      logic [6:0] f7;
      case ($urandom_range(0, 8))
         0: op = O_OP;   1: op = O_LOAD; 2: op = O_STORE; 3: op = O_BR; 4: op = O_LUI;
         5: op = O_AUIPC; 6: op = O_JAL; 7: op = O_JALR;  default: op = O_IMM;
      endcase
      case ($urandom_range(0, 2))
         0: f7 = 7'h00; 1: f7 = 7'h01; default: f7 = 7'h20;
      endcase
      return mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f7);
   endfunction

   task automatic drive(logic [31:0] e, logic [31:0] m, logic [31:0] w, logic wm, logic ww, logic tk);
      instr_E = e; instr_M = m; instr_W = w;
      reg_wr_en_M = wm; reg_wr_en_W = ww; is_taken = tk;
   endtask

   task automatic test_reset;
      drive(mk(O_OP, 9, 3, 5, 7'h01), mk(O_LOAD, 3, 0, 0, 0), mk(O_OP, 5, 0, 0, 0), 1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 2; c++) begin
         #1;
         n_tests++; if (ctl_a !== C_NORM) begin n_fail++; $display("FAIL reset_ctl_a[%0d]: got %b want %b", c, ctl_a, C_NORM); end
         n_tests++; if (ctl_b !== C_NORM) begin n_fail++; $display("FAIL reset_ctl_b[%0d]: got %b want %b", c, ctl_b, C_NORM); end
         n_tests++; if ({fa_a, fb_a, fa_b, fb_b} !== 8'h00) begin n_fail++; $display("FAIL reset_fwd[%0d]: got %b want 00000000", c, {fa_a, fb_a, fa_b, fb_b}); end
         n_tests++; if ({st_a, fl_a} !== 64'd0) begin n_fail++; $display("FAIL reset_counters[%0d]: got %0d/%0d want 0/0", c, st_a, fl_a); end
         @(posedge clk); #1;
      end
      drive(mk(O_IMM, 0, 0, 0, 0), mk(O_IMM, 0, 0, 0, 0), mk(O_IMM, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_forwarding;
      logic [31:0] te[6], tm[6], tw[6];
      logic        twm[6], tww[6];
      logic [3:0]  texp[6];
      te  = '{mk(O_OP,6,3,4,7'h20), mk(O_OP,6,3,4,7'h20), mk(O_OP,6,3,4,7'h20), mk(O_OP,6,3,4,7'h20), mk(O_OP,6,1,3,0), mk(O_OP,6,3,3,0)};
      tm  = '{mk(O_OP,3,1,2,0), mk(O_OP,0,1,2,0), mk(O_OP,3,1,2,0), mk(O_OP,3,1,2,0), mk(O_OP,3,1,2,0), mk(O_OP,5,1,2,0)};
      tw  = '{mk(O_OP,3,0,0,0), mk(O_OP,3,0,0,0), mk(O_OP,3,0,0,0), mk(O_OP,3,0,0,0), mk(O_OP,3,0,0,0), mk(O_OP,3,0,0,0)};
      twm = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tww = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      texp = '{4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b1010};
      for (int i = 0; i < 6; i++) begin
         drive(te[i], tm[i], tw[i], twm[i], tww[i], 1'b0);
         #1;
         n_tests++; if ({fa_a, fb_a} !== texp[i]) begin n_fail++; $display("FAIL fwd_a[%0d]: got %b want %b", i, {fa_a, fb_a}, texp[i]); end
         n_tests++; if ({fa_b, fb_b} !== texp[i]) begin n_fail++; $display("FAIL fwd_b[%0d]: got %b want %b", i, {fa_b, fb_b}, texp[i]); end
         n_tests++; if (ctl_a !== C_NORM) begin n_fail++; $display("FAIL fwd_nostall[%0d]: got %b want %b", i, ctl_a, C_NORM); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use;
      logic [9:0]  exp_a[4];
      logic [31:0] base;
      int          low = 0;
      exp_a = '{C_HOLD, C_HOLD, C_REL, C_NORM};
      base = st_a;
      drive(mk(O_OP, 9, 1, 5, 0), mk(O_LOAD, 5, 0, 0, 0), mk(O_IMM, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         if (c == 3) drive(mk(O_OP, 9, 1, 5, 0), mk(O_IMM, 0, 0, 0, 0), mk(O_LOAD, 5, 0, 0, 0), 1'b0, 1'b1, 1'b0);
         #1;
         n_tests++; if (ctl_a !== exp_a[c]) begin n_fail++; $display("FAIL load_use_a[%0d]: got %b want %b", c, ctl_a, exp_a[c]); end
         if (c == 0) begin
            n_tests++; if (ctl_b !== C_REL) begin n_fail++; $display("FAIL load_use_lat1: got %b want %b", ctl_b, C_REL); end
         end
         if (c == 3) begin
            n_tests++; if ({fa_a, fb_a} !== 4'b0010) begin n_fail++; $display("FAIL load_use_fwd: got %b want 0010", {fa_a, fb_a}); end
         end
         if (!ctl_a[9]) low++;
         @(posedge clk); #1;
      end
      n_tests++; if (low != 3) begin n_fail++; $display("FAIL load_use_pc_low: got %0d want 3", low); end
`ifdef HAZARD_PERF_EN
      n_tests++; if (st_a - base !== 32'd3) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d want 3", st_a - base); end
`endif
   endtask

   task automatic test_no_stall;
      logic [31:0] te[4], tm[4];
      te = '{mk(O_LUI, 5, 5, 5, 0), mk(O_OP, 6, 0, 0, 0), mk(O_IMM, 6, 6, 5, 0), mk(O_JAL, 1, 5, 5, 0)};
      tm = '{mk(O_LOAD, 5, 0, 0, 0), mk(O_LOAD, 0, 0, 0, 0), mk(O_LOAD, 5, 0, 0, 0), mk(O_LOAD, 5, 0, 0, 0)};
      for (int i = 0; i < 4; i++) begin
         drive(te[i], tm[i], mk(O_IMM, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
         #1;
         n_tests++; if (ctl_a !== C_NORM) begin n_fail++; $display("FAIL no_stall_a[%0d]: got %b want %b", i, ctl_a, C_NORM); end
         n_tests++; if (ctl_b !== C_NORM) begin n_fail++; $display("FAIL no_stall_b[%0d]: got %b want %b", i, ctl_b, C_NORM); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mdu_back_to_back;
      logic [9:0] exp_a[8];
      int         low = 0;
      exp_a = '{C_MDUS, C_REL, C_REL, C_NORM, C_MDUS, C_REL, C_REL, C_NORM};
      for (int c = 0; c < 8; c++) begin
         drive((c < 4) ? mk(O_OP, 7, 1, 2, 7'h01) : mk(O_OP, 8, 3, 2, 7'h01),
               mk(O_IMM, 0, 0, 0, 0), mk(O_IMM, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
         #1;
         n_tests++; if (ctl_a !== exp_a[c]) begin n_fail++; $display("FAIL mdu_a[%0d]: got %b want %b", c, ctl_a, exp_a[c]); end
         n_tests++; if (ctl_b !== C_NORM) begin n_fail++; $display("FAIL mdu_lat1[%0d]: got %b want %b", c, ctl_b, C_NORM); end
         if (!ctl_a[9]) low++;
         @(posedge clk); #1;
      end
      n_tests++; if (low != 6) begin n_fail++; $display("FAIL mdu_pc_low: got %0d want 6", low); end
   endtask

   task automatic test_load_back_to_back;
      logic [9:0] exp_a[7];
      exp_a = '{C_HOLD, C_HOLD, C_REL, C_HOLD, C_HOLD, C_REL, C_NORM};
      for (int c = 0; c < 7; c++) begin
         if (c == 0) drive(mk(O_STORE, 0, 1, 5, 0), mk(O_LOAD, 5, 0, 0, 0), mk(O_IMM, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
         if (c == 3) drive(mk(O_OP, 9, 6, 5, 0), mk(O_LOAD, 6, 0, 0, 0), mk(O_LOAD, 5, 0, 0, 0), 1'b1, 1'b1, 1'b0);
         if (c == 6) drive(mk(O_OP, 9, 6, 5, 0), mk(O_IMM, 0, 0, 0, 0), mk(O_LOAD, 6, 0, 0, 0), 1'b0, 1'b1, 1'b0);
         #1;
         n_tests++; if (ctl_a !== exp_a[c]) begin n_fail++; $display("FAIL load_b2b_a[%0d]: got %b want %b", c, ctl_a, exp_a[c]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch;
      logic [31:0] te[9], tm[9];
      logic        twm[9], ttk[9];
      logic [9:0]  ea[9], eb[9];
      logic [31:0] base;
      te  = '{mk(O_BR,0,1,2,0), mk(O_BR,0,1,2,0), mk(O_OP,4,1,2,0), mk(O_JALR,1,1,0,0), mk(O_JAL,1,0,0,0),
              mk(O_BR,0,5,2,0), mk(O_BR,0,5,2,0), mk(O_BR,0,5,2,0), mk(O_BR,0,5,2,0)};
      tm  = '{mk(O_IMM,0,0,0,0), mk(O_IMM,0,0,0,0), mk(O_IMM,0,0,0,0), mk(O_IMM,0,0,0,0), mk(O_IMM,0,0,0,0),
              mk(O_LOAD,5,0,0,0), mk(O_LOAD,5,0,0,0), mk(O_LOAD,5,0,0,0), mk(O_IMM,0,0,0,0)};
      twm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ttk = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      ea  = '{C_BR, C_NORM, C_NORM, C_BR, C_BR, C_HOLD, C_HOLD, C_REL, C_BR};
      eb  = '{C_BR, C_NORM, C_NORM, C_BR, C_BR, C_REL, C_REL, C_REL, C_BR};
      base = fl_a;
      for (int i = 0; i < 9; i++) begin
         drive(te[i], tm[i], mk(O_IMM, 0, 0, 0, 0), twm[i], 1'b0, ttk[i]);
         #1;
         n_tests++; if (ctl_a !== ea[i]) begin n_fail++; $display("FAIL branch_a[%0d]: got %b want %b", i, ctl_a, ea[i]); end
         n_tests++; if (ctl_b !== eb[i]) begin n_fail++; $display("FAIL branch_b[%0d]: got %b want %b", i, ctl_b, eb[i]); end
         @(posedge clk); #1;
      end
`ifdef HAZARD_PERF_EN
      n_tests++; if (fl_a - base !== 32'd4) begin n_fail++; $display("FAIL branch_flush_cnt: got %0d want 4", fl_a - base); end
`endif
   endtask

   task automatic test_reset_mid_stall;
      logic [9:0] exp_a[4];
      exp_a = '{C_MDUS, C_REL, C_REL, C_NORM};
      drive(mk(O_OP, 7, 1, 2, 7'h01), mk(O_OP, 1, 0, 0, 0), mk(O_IMM, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++; if (ctl_a !== exp_a[c]) begin n_fail++; $display("FAIL rst_mid_pre[%0d]: got %b want %b", c, ctl_a, exp_a[c]); end
         if (c < 2) begin @(posedge clk); #1; end
      end
      rst = 1'b1;
      #1;
      n_tests++; if (ctl_a !== C_NORM) begin n_fail++; $display("FAIL rst_mid_async: got %b want %b", ctl_a, C_NORM); end
      n_tests++; if (fa_a !== 2'b00) begin n_fail++; $display("FAIL rst_mid_fwd: got %b want 00", fa_a); end
      @(posedge clk); #1;
      n_tests++; if ({st_a, fl_a} !== 64'd0) begin n_fail++; $display("FAIL rst_mid_counters: got %0d/%0d want 0/0", st_a, fl_a); end
      drive(mk(O_IMM, 0, 0, 0, 0), mk(O_IMM, 0, 0, 0, 0), mk(O_IMM, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++; if (ctl_a !== C_NORM) begin n_fail++; $display("FAIL rst_mid_idle[%0d]: got %b want %b", c, ctl_a, C_NORM); end
         @(posedge clk); #1;
      end
      drive(mk(O_OP, 7, 1, 2, 7'h01), mk(O_IMM, 0, 0, 0, 0), mk(O_IMM, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         #1;
         n_tests++; if (ctl_a !== exp_a[c]) begin n_fail++; $display("FAIL rst_mid_restart[%0d]: got %b want %b", c, ctl_a, exp_a[c]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random;
      logic [31:0] e, m, w, base_st, base_fl;
      logic        wm, ww, tk, lu, br;
      logic [9:0]  exp_a, exp_b;
      logic [3:0]  efwd;
      int          n_st = 0, n_fl = 0;
      sched_a.delete();
      base_st = st_a;
      base_fl = fl_a;
      for (int c = 0; c < 3000; c++) begin
         e = rnd_instr(); m = rnd_instr(); w = rnd_instr();
         wm = 1'($urandom_range(0, 1)); ww = 1'($urandom_range(0, 1)); tk = 1'($urandom_range(0, 1));
         drive(e, m, w, wm, ww, tk);
         #1;
         lu = ref_load_use(e, m, wm);
         br = ref_branch(e, tk);
         // a stall is modelled as a pre-computed schedule of per-cycle control patterns
         if (sched_a.size() > 0) begin
            exp_a = sched_a.pop_front();
         end else if (lu) begin
            exp_a = C_HOLD;
            sched_a.push_back(C_HOLD);
            sched_a.push_back(C_REL);
         end else if (ref_mul(e)) begin
            exp_a = C_MDUS;
            sched_a.push_back(C_REL);
            sched_a.push_back(C_REL);
            sched_a.push_back(C_NORM);
         end else begin
            exp_a = br ? C_BR : C_NORM;
         end
         exp_b = lu ? C_REL : (br ? C_BR : C_NORM);
         efwd = {ref_fwd(e[19:15], m, wm, w, ww), ref_fwd(e[24:20], m, wm, w, ww)};
         if (!exp_a[9]) n_st++;
         if (exp_a == C_BR) n_fl++;
         n_tests++; if (ctl_a !== exp_a) begin n_fail++; $display("FAIL rand_ctl_a[%0d]: got %b want %b", c, ctl_a, exp_a); end
         n_tests++; if (ctl_b !== exp_b) begin n_fail++; $display("FAIL rand_ctl_b[%0d]: got %b want %b", c, ctl_b, exp_b); end
         n_tests++; if ({fa_a, fb_a} !== efwd) begin n_fail++; $display("FAIL rand_fwd_a[%0d]: got %b want %b", c, {fa_a, fb_a}, efwd); end
         n_tests++; if ({fa_b, fb_b} !== efwd) begin n_fail++; $display("FAIL rand_fwd_b[%0d]: got %b want %b", c, {fa_b, fb_b}, efwd); end
         @(posedge clk); #1;
      end
`ifdef HAZARD_PERF_EN
      n_tests++; if (st_a - base_st !== 32'(n_st)) begin n_fail++; $display("FAIL rand_stall_cnt: got %0d want %0d", st_a - base_st, n_st); end
      n_tests++; if (fl_a - base_fl !== 32'(n_fl)) begin n_fail++; $display("FAIL rand_flush_cnt: got %0d want %0d", fl_a - base_fl, n_fl); end
`else
      n_tests++; if ({st_a, fl_a} !== 64'd0 || n_st < 0 || n_fl < 0 || base_st !== base_fl) begin n_fail++; $display("FAIL rand_counters_tied: got %0d/%0d want 0/0", st_a, fl_a); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_forwarding();
      test_load_use();
      test_no_stall();
      test_mdu_back_to_back();
      test_load_back_to_back();
      test_branch();
      test_reset_mid_stall();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
